// File: rtl/move_sequencer_if.sv
// Bus-side bundle of the move sequencer: control inputs, instruction data, ack,
// one-hot unit enables, status flags and move count. master = sequencer, slave = bus/units.
interface move_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int UNIT_NUM   = 16,
   parameter int CNT_WIDTH  = 16
);
   logic                  i_start;
   logic [DATA_WIDTH-1:0] i_ins;
   logic                  i_ack;
   logic                  i_resume;
   logic [UNIT_NUM-1:0]   o_unit_oen;
   logic [UNIT_NUM-1:0]   o_unit_ien;
   logic                  o_busy;
   logic                  o_halt;
   logic                  o_err;
   logic [CNT_WIDTH-1:0]  o_move_cnt;

   modport master (
      input  i_start, i_ins, i_ack, i_resume,
      output o_unit_oen, o_unit_ien, o_busy, o_halt, o_err, o_move_cnt
   );

   modport slave (
      output i_start, i_ins, i_ack, i_resume,
      input  o_unit_oen, o_unit_ien, o_busy, o_halt, o_err, o_move_cnt
   );
endinterface

// File: rtl/move_sequencer.sv
// Move-instruction sequencer: fetches src/tgt select pairs and drives one-hot unit enables.
// Ports: clk, rst_n (async, active low), bus (move_sequencer_if.master).
module move_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int SEL_WIDTH  = 4,
   parameter int UNIT_NUM   = 16,
   parameter int SEL_IR     = 0,
   parameter int SEL_INS_PC = 11,
   parameter int SEL_NULL   = 15,
   parameter int TIMEOUT    = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   move_sequencer_if.master bus
);

   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_HALT,
      S_ERROR
   } state_t;

   state_t                state;
   state_t                nxt_state;
   logic [DATA_WIDTH-1:0] ir;
   logic [DATA_WIDTH-1:0] nxt_ir;
   logic [WW-1:0]         wcnt;
   logic [WW-1:0]         nxt_wcnt;
   logic                  cnt_inc;
   logic                  timeout_hit;
   logic [UNIT_NUM-1:0]   nxt_oen;
   logic [UNIT_NUM-1:0]   nxt_ien;

   function automatic logic [SEL_WIDTH-1:0] src_of(input logic [DATA_WIDTH-1:0] v);
      return v[2*SEL_WIDTH-1:SEL_WIDTH];
   endfunction

   function automatic logic [SEL_WIDTH-1:0] tgt_of(input logic [DATA_WIDTH-1:0] v);
      return v[SEL_WIDTH-1:0];
   endfunction

   // Null or out-of-range codes decode to no enable at all.
   function automatic logic [UNIT_NUM-1:0] dec(input logic [SEL_WIDTH-1:0] code);
      logic [UNIT_NUM-1:0] r;
      r = '0;
      for (int k = 0; k < UNIT_NUM; k++) begin
         if (k == int'(code) && int'(code) != SEL_NULL) r[k] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic is_halt(input logic [DATA_WIDTH-1:0] v);
      return int'(src_of(v)) == SEL_NULL;
   endfunction

   function automatic logic is_bad(input logic [DATA_WIDTH-1:0] v);
      logic s_bad;
      logic t_bad;
      s_bad = int'(src_of(v)) >= UNIT_NUM;
      t_bad = int'(tgt_of(v)) != SEL_NULL && int'(tgt_of(v)) >= UNIT_NUM;
      return !is_halt(v) && (s_bad || t_bad);
   endfunction

   // Fires in the last allowed no-ack cycle; a same-cycle ack still wins.
   assign timeout_hit = (TIMEOUT > 0) && (int'(wcnt) == TIMEOUT - 1);

   always_comb begin
      nxt_state = state;
      nxt_ir    = ir;
      nxt_wcnt  = wcnt;
      cnt_inc   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.i_start) nxt_state = S_FETCH;
         end
         S_FETCH: begin
            if (bus.i_ack) begin
               nxt_ir    = bus.i_ins;
               nxt_state = S_EXEC;
            end else if (timeout_hit) begin
               nxt_state = S_ERROR;
            end else begin
               nxt_wcnt = wcnt + WW'(1);
            end
         end
         S_EXEC: begin
            if (is_halt(ir)) begin
               nxt_state = S_HALT;
            end else if (is_bad(ir)) begin
               nxt_state = S_ERROR;
            end else if (bus.i_ack) begin
               cnt_inc  = 1'b1;
               nxt_wcnt = '0;
               if (int'(tgt_of(ir)) == SEL_IR) nxt_ir = bus.i_ins;
               else nxt_state = S_FETCH;
            end else if (timeout_hit) begin
               nxt_state = S_ERROR;
            end else begin
               nxt_wcnt = wcnt + WW'(1);
            end
         end
         S_HALT, S_ERROR: begin
            if (bus.i_resume) nxt_state = S_FETCH;
         end
         default: nxt_state = S_IDLE;
      endcase
      if (nxt_state != state) nxt_wcnt = '0;
   end

   // Enables are registered from the next state/ir so they line up with the state register.
   always_comb begin
      nxt_oen = '0;
      nxt_ien = '0;
      if (nxt_state == S_FETCH) begin
         nxt_oen = dec(SEL_WIDTH'(SEL_INS_PC));
         nxt_ien = dec(SEL_WIDTH'(SEL_IR));
      end else if (nxt_state == S_EXEC && !is_halt(nxt_ir) && !is_bad(nxt_ir)) begin
         nxt_oen = dec(src_of(nxt_ir));
         nxt_ien = dec(tgt_of(nxt_ir));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         ir             <= '0;
         wcnt           <= '0;
         bus.o_unit_oen <= '0;
         bus.o_unit_ien <= '0;
         bus.o_busy     <= 1'b0;
         bus.o_halt     <= 1'b0;
         bus.o_err      <= 1'b0;
         bus.o_move_cnt <= '0;
      end else begin
         state          <= nxt_state;
         ir             <= nxt_ir;
         wcnt           <= nxt_wcnt;
         bus.o_unit_oen <= nxt_oen;
         bus.o_unit_ien <= nxt_ien;
         bus.o_busy     <= (nxt_state == S_FETCH) || (nxt_state == S_EXEC);
         bus.o_halt     <= nxt_state == S_HALT;
         bus.o_err      <= nxt_state == S_ERROR;
         bus.o_move_cnt <= bus.o_move_cnt + CNT_WIDTH'(cnt_inc);
      end
   end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: default 16-unit instance plus an 8-unit
// instance for out-of-range selects and asynchronous reset mid-move.
module tb_move_sequencer;

   logic clk;
   logic rst_n;
   logic rst_b_n;
   int   total;
   int   passed;

   move_sequencer_if #(.DATA_WIDTH(8), .UNIT_NUM(16), .CNT_WIDTH(16)) a ();
   move_sequencer_if #(.DATA_WIDTH(8), .UNIT_NUM(8), .CNT_WIDTH(16)) b ();

   move_sequencer dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a.master)
   );

   move_sequencer #(
      .UNIT_NUM   (8),
      .SEL_INS_PC (6)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_b_n),
      .bus   (b.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      total      = 0;
      passed     = 0;
      rst_n      = 1'b0;
      rst_b_n    = 1'b0;
      a.i_start  = 1'b0;
      a.i_ins    = '0;
      a.i_ack    = 1'b0;
      a.i_resume = 1'b0;
      b.i_start  = 1'b0;
      b.i_ins    = '0;
      b.i_ack    = 1'b0;
      b.i_resume = 1'b0;
      tick(2);
      chk("rst_oen", a.o_unit_oen, 16'h0000);
      chk("rst_ien", a.o_unit_ien, 16'h0000);
      chk("rst_flags", {a.o_busy, a.o_halt, a.o_err}, 3'b000);
      chk("rst_cnt", a.o_move_cnt, 16'd0);
      rst_n = 1'b1;

      // idle without start
      tick(5);
      chk("idle_oen", a.o_unit_oen, 16'h0000);
      chk("idle_busy", a.o_busy, 1'b0);

      a.i_start = 1'b1;
      tick();
      a.i_start = 1'b0;
      chk("fetch_oen", a.o_unit_oen, 16'h0800);
      chk("fetch_ien", a.o_unit_ien, 16'h0001);
      chk("fetch_busy", a.o_busy, 1'b1);

      // move 3 -> 4
      a.i_ins = 8'h34;
      a.i_ack = 1'b1;
      tick();
      chk("exec34_oen", a.o_unit_oen, 16'h0008);
      chk("exec34_ien", a.o_unit_ien, 16'h0010);
      tick();
      chk("move1_cnt", a.o_move_cnt, 16'd1);
      chk("move1_fetch", a.o_unit_oen, 16'h0800);

      // null source halts
      a.i_ins = 8'hF2;
      tick();
      chk("halt_entry_oen", a.o_unit_oen, 16'h0000);
      chk("halt_entry_busy", a.o_busy, 1'b1);
      tick();
      a.i_ack = 1'b0;
      chk("halt_flag", a.o_halt, 1'b1);
      chk("halt_en", {a.o_unit_oen, a.o_unit_ien}, 32'h0);
      chk("halt_cnt", a.o_move_cnt, 16'd1);
      a.i_start = 1'b1;
      tick();
      a.i_start = 1'b0;
      chk("halt_ignore_start", a.o_halt, 1'b1);
      a.i_resume = 1'b1;
      tick();
      a.i_resume = 1'b0;
      chk("resume_fetch", a.o_unit_oen, 16'h0800);
      chk("resume_halt_clr", a.o_halt, 1'b0);

      // timeout in EXEC after 16 cycles without ack
      a.i_ins = 8'h30;
      a.i_ack = 1'b1;
      tick();
      a.i_ack = 1'b0;
      chk("exec30_oen", a.o_unit_oen, 16'h0008);
      chk("exec30_ien", a.o_unit_ien, 16'h0001);
      tick(15);
      chk("wait15_busy", a.o_busy, 1'b1);
      chk("wait15_err", a.o_err, 1'b0);
      tick();
      chk("timeout_err", a.o_err, 1'b1);
      chk("timeout_en", a.o_unit_oen, 16'h0000);
      chk("timeout_cnt", a.o_move_cnt, 16'd1);
      a.i_resume = 1'b1;
      tick();
      a.i_resume = 1'b0;
      chk("err_resume", a.o_unit_oen, 16'h0800);

      // ack in the 16th cycle wins over timeout; tgt IR chains
      a.i_ins = 8'h30;
      a.i_ack = 1'b1;
      tick();
      a.i_ack = 1'b0;
      tick(15);
      a.i_ins = 8'h34;
      a.i_ack = 1'b1;
      tick();
      chk("late_ack_err", a.o_err, 1'b0);
      chk("late_ack_cnt", a.o_move_cnt, 16'd2);
      chk("chain34_oen", a.o_unit_oen, 16'h0008);
      chk("chain34_ien", a.o_unit_ien, 16'h0010);
      tick();
      chk("move3_cnt", a.o_move_cnt, 16'd3);

      // chained load 2 -> IR, then 4 -> 5
      a.i_ins = 8'h20;
      tick();
      chk("exec20_oen", a.o_unit_oen, 16'h0004);
      chk("exec20_ien", a.o_unit_ien, 16'h0001);
      a.i_ins = 8'h45;
      tick();
      chk("chain45_oen", a.o_unit_oen, 16'h0010);
      chk("chain45_ien", a.o_unit_ien, 16'h0020);
      chk("chain45_cnt", a.o_move_cnt, 16'd4);
      tick();
      chk("move5_cnt", a.o_move_cnt, 16'd5);

      // null target still needs an ack
      a.i_ins = 8'h3F;
      tick();
      chk("exec3f_oen", a.o_unit_oen, 16'h0008);
      chk("exec3f_ien", a.o_unit_ien, 16'h0000);
      tick();
      chk("move6_cnt", a.o_move_cnt, 16'd6);
      a.i_ack = 1'b0;

      // timeout in FETCH
      tick(15);
      chk("fwait_err", a.o_err, 1'b0);
      tick();
      chk("ftimeout_err", a.o_err, 1'b1);
      chk("ftimeout_busy", a.o_busy, 1'b0);

      // 8-unit instance
      rst_b_n = 1'b1;
      b.i_start = 1'b1;
      tick();
      b.i_start = 1'b0;
      chk("b_fetch_oen", b.o_unit_oen, 8'h40);
      chk("b_fetch_ien", b.o_unit_ien, 8'h01);
      b.i_ins = 8'h39;
      b.i_ack = 1'b1;
      tick();
      chk("b_bad_en", {b.o_unit_oen, b.o_unit_ien}, 16'h0000);
      tick();
      chk("b_bad_err", b.o_err, 1'b1);
      chk("b_bad_cnt", b.o_move_cnt, 16'd0);
      b.i_ack = 1'b0;
      b.i_resume = 1'b1;
      tick();
      b.i_resume = 1'b0;
      b.i_ins = 8'h32;
      b.i_ack = 1'b1;
      tick();
      chk("b_exec32_oen", b.o_unit_oen, 8'h08);
      chk("b_exec32_ien", b.o_unit_ien, 8'h04);
      tick();
      chk("b_move1_cnt", b.o_move_cnt, 16'd1);
      tick();
      b.i_ack = 1'b0;
      chk("b_exec_again", b.o_unit_oen, 8'h08);
      #2;
      rst_b_n = 1'b0;
      #1;
      chk("b_async_oen", b.o_unit_oen, 8'h00);
      chk("b_async_ien", b.o_unit_ien, 8'h00);
      chk("b_async_cnt", b.o_move_cnt, 16'd0);
      chk("b_async_busy", b.o_busy, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
